// File: rtl/ysyx_22040759_ifu_if.sv
// ============================================================================
// Module : ysyx_22040759_ifu_if
// Brief  : Bundles the IFU redirect/halt, memory req/rsp and decode inst signals.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_22040759_ifu_if #(
  parameter int PC_W = 64
);
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [PC_W-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] pc_o;
  logic            misalign;

  // IFU side
  modport master (
    input  redirect_valid, redirect_pc, halt,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst, pc_o, misalign
  );

  // Environment side (execute, instruction memory, decode)
  modport slave (
    output redirect_valid, redirect_pc, halt,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst, pc_o, misalign
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040759_ifu.sv
// ============================================================================
// Module : ysyx_22040759_ifu
// Brief  : Instruction fetch unit - owns the PC, fetches one word at a time
//          and holds it for decode; handles redirects, halt and squashing.
//          Optional macro IFU_MISALIGN_CHK_EN enables misaligned-target trap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040759_ifu #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  ysyx_22040759_ifu_if.master     bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  localparam logic [31:0]     C_NOP  = 32'h0000_0013;
  localparam logic [PC_W-1:0] C_STEP = PC_W'(4);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc_o_q, pc_o_d;

  logic w_active;
  logic w_mis_redir;
  logic w_redir;
  logic w_stop;

  assign w_active = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_HOLD);

`ifdef IFU_MISALIGN_CHK_EN
  assign w_mis_redir = w_active && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign w_mis_redir = 1'b0;
`endif

  assign w_redir = w_active && bus.redirect_valid && !w_mis_redir;
  // Any stop cause blocks new requests in the same cycle it appears.
  assign w_stop  = halted_q || bus.halt || misalign_q || w_mis_redir;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    pc_o_d     = pc_o_q;
    halted_d   = halted_q || bus.halt;
    misalign_d = misalign_q || w_mis_redir;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (w_redir) begin
          pc_d = bus.redirect_pc;
        end
        if (w_stop) begin
          state_d = S_STOP;
        end else if (bus.mem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = w_redir;
        end
      end

      S_WAIT: begin
        if (w_redir) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.mem_rsp_valid) begin
          // A redirect landing with the response squashes it just like drop.
          if (drop_q || w_redir || w_mis_redir) begin
            drop_d  = 1'b0;
            state_d = w_stop ? S_STOP : S_REQ;
          end else begin
            inst_d  = bus.mem_rsp_data;
            pc_o_d  = pc_q;
            state_d = S_HOLD;
          end
        end else if (w_redir || w_mis_redir) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_redir || w_mis_redir) begin
          if (w_redir) begin
            pc_d = bus.redirect_pc;
          end
          state_d = w_stop ? S_STOP : S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + C_STEP;
          state_d = w_stop ? S_STOP : S_REQ;
        end
      end

      S_STOP: begin
        state_d = S_STOP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      inst_q     <= C_NOP;
      pc_o_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      inst_q     <= inst_d;
      pc_o_q     <= pc_o_d;
    end
  end

  assign bus.mem_req_valid = (state_q == S_REQ) && !w_stop;
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.pc_o          = pc_o_q;
  assign bus.misalign      = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040759_ifu.sv
// ============================================================================
// Module : tb_ysyx_22040759_ifu
// Brief  : Directed cycle-by-cycle bench for the IFU with a hand-driven memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040759_ifu;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  ysyx_22040759_ifu_if #(.PC_W(64)) bus ();

  ysyx_22040759_ifu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.inst_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid",  64'(bus.mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid),    64'd0);
    chk("rst_inst",       64'(bus.inst),          64'h13);
    chk("rst_pc_o",       bus.pc_o,               64'd0);
    chk("rst_misalign",   64'(bus.misalign),      64'd0);
    chk("rst_addr",       bus.mem_req_addr,       64'h8000_0000);

    // First fetch, 1-cycle memory
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b1;
    chk("idle_req_valid", 64'(bus.mem_req_valid), 64'd0);
    tick();
    chk("req0_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("req0_addr",  bus.mem_req_addr,       64'h8000_0000);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0297;
    chk("wait0_req_valid",  64'(bus.mem_req_valid), 64'd0);
    chk("wait0_inst_valid", 64'(bus.inst_valid),    64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("hold0_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("hold0_inst",       64'(bus.inst),       64'h0000_0297);
    chk("hold0_pc_o",       bus.pc_o,            64'h8000_0000);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst_valid", 64'(bus.inst_valid),    64'd1);
      chk("stall_inst",       64'(bus.inst),          64'h0000_0297);
      chk("stall_pc_o",       bus.pc_o,               64'h8000_0000);
      chk("stall_no_req",     64'(bus.mem_req_valid), 64'd0);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("req1_valid",      64'(bus.mem_req_valid), 64'd1);
    chk("req1_addr",       bus.mem_req_addr,       64'h8000_0004);
    chk("req1_inst_valid", 64'(bus.inst_valid),    64'd0);

    // Redirect while waiting: stale response discarded
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = 32'hDEAD_BEEF;
    chk("drop_inst_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("redir_inst_valid", 64'(bus.inst_valid),    64'd0);
    chk("redir_req_valid",  64'(bus.mem_req_valid), 64'd1);
    chk("redir_req_addr",   bus.mem_req_addr,       64'h8000_0100);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0010_0093;
    chk("redir_wait_inst_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("redir_hold_valid", 64'(bus.inst_valid), 64'd1);
    chk("redir_hold_inst",  64'(bus.inst),       64'h0010_0093);
    chk("redir_hold_pc_o",  bus.pc_o,            64'h8000_0100);

    // Redirect in HOLD with inst_ready=1: target wins over pc+4
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    bus.inst_ready     = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.mem_req_ready  = 1'b0;
    chk("hredir_inst_valid", 64'(bus.inst_valid),    64'd0);
    chk("hredir_req_valid",  64'(bus.mem_req_valid), 64'd1);
    chk("hredir_req_addr",   bus.mem_req_addr,       64'h8000_0200);

    // Memory back-pressure for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_req_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("bp_req_addr",  bus.mem_req_addr,       64'h8000_0200);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0020_0113;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("bp_hold_valid", 64'(bus.inst_valid), 64'd1);
    chk("bp_hold_pc_o",  bus.pc_o,            64'h8000_0200);
    chk("bp_hold_inst",  64'(bus.inst),       64'h0020_0113);

    // Halt in HOLD, then consume -> STOP
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("halt_hold_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("stop_inst_valid", 64'(bus.inst_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stop_no_req", 64'(bus.mem_req_valid), 64'd0);
    end

    // Second reset: PC wrap-around at the top of the address space
    rst_n = 1'b0;
    bus.mem_req_ready = 1'b0;
    #1;
    chk("rst2_inst", 64'(bus.inst), 64'h13);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_req_valid", 64'(bus.mem_req_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_req_addr", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0013;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("wrap_hold_pc_o", bus.pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("wrap_next_addr",  bus.mem_req_addr,       64'd0);
    chk("wrap_next_valid", 64'(bus.mem_req_valid), 64'd1);

    // Misaligned redirect target
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0102;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_flag",      64'(bus.misalign),      64'd1);
    chk("mis_req_valid", 64'(bus.mem_req_valid), 64'd0);
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_no_req",    64'(bus.mem_req_valid), 64'd0);
      chk("mis_sticky",    64'(bus.misalign),      64'd1);
    end
`else
    chk("mis_flag",      64'(bus.misalign),      64'd0);
    chk("mis_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("mis_req_addr",  bus.mem_req_addr,       64'h8000_0102);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
